// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM pipeline register.
// Build option: EX_MEM_BRANCH_RESOLVE_EN keeps branch state in this stage.
package ex_mem_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;
    localparam int CTRL_W     = 5;

    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_MEMREAD  = 3;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_BRANCH   = 0;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] alu_result;
        logic                  zero;
        logic [DEF_DATA_W-1:0] wdata;
        logic [DEF_REG_W-1:0]  wreg;
        logic [CTRL_W-1:0]     ctrl;
        logic [DEF_DATA_W-1:0] target;
    } ex_mem_entry_t;

endpackage

// File: rtl/ex_mem_entry_reg.sv
// One pipeline entry with its valid bit; payload is never reset.
// Build option: EX_MEM_BRANCH_RESOLVE_EN keeps zero/branch/target flops.
module ex_mem_entry_reg
    import ex_mem_pkg::*;
(
    input  logic          Clk,
    input  logic          Rst,
    input  logic          load,
    input  logic          clear,
    input  ex_mem_entry_t d,
    output logic          valid,
    output ex_mem_entry_t q
);

    // clear wins over load so a flush always empties the entry
    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

`ifdef EX_MEM_BRANCH_RESOLVE_EN
    always_ff @(posedge Clk) begin
        if (load) begin
            q <= d;
        end
    end
`else
    logic [DEF_DATA_W-1:0] alu_q;
    logic [DEF_DATA_W-1:0] wdata_q;
    logic [DEF_REG_W-1:0]  wreg_q;
    logic [CTRL_W-1:1]     ctrl_q;
    logic                  unused_branch;

    always_ff @(posedge Clk) begin
        if (load) begin
            alu_q   <= d.alu_result;
            wdata_q <= d.wdata;
            wreg_q  <= d.wreg;
            ctrl_q  <= d.ctrl[CTRL_W-1:1];
        end
    end

    // branch resolves elsewhere: no storage for zero, branch bit or target
    always_comb begin
        q                   = '0;
        q.alu_result        = alu_q;
        q.wdata             = wdata_q;
        q.wreg              = wreg_q;
        q.ctrl[CTRL_W-1:1]  = ctrl_q;
    end

    assign unused_branch = ^{d.zero, d.target, d.ctrl[CTRL_BRANCH]};
`endif

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a two-entry skid buffer (main + skid).
// Build option: EX_MEM_BRANCH_RESOLVE_EN drives PCSrc/PCBranch from main.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic              Zero,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [REG_W-1:0]  WriteReg,
    input  logic [4:0]        Ctrl,
    input  logic [DATA_W-1:0] BranchTarget,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic [REG_W-1:0]  MemWriteReg,
    output logic [4:0]        MemCtrl,
    output logic              PCSrc,
    output logic [DATA_W-1:0] PCBranch
);

    ex_mem_entry_t in_d;
    ex_mem_entry_t main_d;
    ex_mem_entry_t main_q;
    ex_mem_entry_t skid_q;
    logic          main_valid;
    logic          skid_valid;
    logic          accept;
    logic          retire;
    logic          main_load;
    logic          main_clear;
    logic          skid_load;
    logic          skid_clear;

    always_comb begin
        in_d            = '0;
        in_d.alu_result = ALUResult;
        in_d.zero       = Zero;
        in_d.wdata      = WriteData;
        in_d.wreg       = WriteReg;
        in_d.ctrl       = Ctrl;
        in_d.target     = BranchTarget;
    end

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready & ~Flush;
    assign retire   = main_valid & out_ready;

    // skid only holds data while in_ready=0, so it never races an accept
    assign main_d     = skid_valid ? skid_q : in_d;
    assign main_load  = ~Flush & ((retire & skid_valid)
                      | (accept & (~main_valid | retire)));
    assign main_clear = Flush | (retire & ~main_load);
    assign skid_load  = accept & main_valid & ~retire;
    assign skid_clear = Flush | (retire & skid_valid);

    ex_mem_entry_reg u_main (
        .Clk   (Clk),
        .Rst   (Rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    ex_mem_entry_reg u_skid (
        .Clk   (Clk),
        .Rst   (Rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_d),
        .valid (skid_valid),
        .q     (skid_q)
    );

    assign out_valid   = main_valid;
    assign MemAddr     = main_q.alu_result;
    assign MemWData    = main_q.wdata;
    assign MemWriteReg = main_q.wreg;
    assign MemCtrl     = main_valid ? main_q.ctrl : 5'd0;

`ifdef EX_MEM_BRANCH_RESOLVE_EN
    assign PCSrc    = main_valid & main_q.ctrl[CTRL_BRANCH] & main_q.zero;
    assign PCBranch = main_q.target;
`else
    assign PCSrc    = 1'b0;
    assign PCBranch = '0;
`endif

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning ALU result, store data and branch target width.
REQ-002 SHALL have parameter REG_W, default 5, meaning destination register index width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have the following ports:
- Clk  in  1  clock, all state updates on rising edge
- Rst  in  1  synchronous active-high reset
- Flush  in  1  discard all held and incoming entries
- in_valid  in  1  EX stage presents an entry
- in_ready  out  1  stage can accept an entry
- ALUResult  in  DATA_W  ALU result
- Zero  in  1  ALU zero flag
- WriteData  in  DATA_W  rt value for stores
- WriteReg  in  REG_W  destination register
- Ctrl  in  5  {RegWrite, MemRead, MemWrite, MemToReg, Branch}
- BranchTarget  in  DATA_W  PC+4+offset
- out_valid  out  1  MEM stage entry valid
- out_ready  in  1  MEM stage accepts the entry
- MemAddr  out  DATA_W  registered ALUResult
- MemWData  out  DATA_W  registered WriteData
- MemWriteReg  out  REG_W  registered WriteReg
- MemCtrl  out  5  registered Ctrl, gated by out_valid
- PCSrc  out  1  branch taken
- PCBranch  out  DATA_W  registered BranchTarget

Function
REQ-005 SHALL hold two entries: main (drives outputs) and skid.
REQ-006 SHALL drive in_ready = NOT skid_valid, taken from a flop with no combinational path from out_ready.
REQ-007 SHALL accept an entry on an edge where in_valid AND in_ready AND NOT Flush.
REQ-008 SHALL retire main on an edge where out_valid AND out_ready.
REQ-009 Accept into empty main, or while main retires with skid empty: entry loads into main; latency 1 cycle, in to out.
REQ-010 Accept while main is held (out_ready=0): entry loads into skid; in_ready falls next cycle.
REQ-011 Main retires with skid valid: skid moves into main and skid empties; no incoming entry is accepted that cycle because in_ready=0.
REQ-012 SHALL keep entries in order with no loss or duplication; throughput is 1 entry/cycle when out_ready=1.
REQ-013 SHALL hold all main payload outputs stable while out_valid=1 and out_ready=0.
REQ-014 Flush SHALL clear main_valid and skid_valid at the edge, with priority over accept and retire.
REQ-015 MemCtrl SHALL be 0 whenever out_valid=0, so bubbles never write.
REQ-016 Payload flops are not reset; only the valid bits and state are.

Reset
REQ-017 At Rst=1, on the edge, out_valid=0, skid empty, in_ready=1, PCSrc=0 and MemCtrl=0; Rst overrides Flush, accept and retire.
REQ-018 Reset mid-operation SHALL drop both held entries; no entry accepted in that cycle survives.

Configuration
REQ-019 Macro EX_MEM_BRANCH_RESOLVE_EN:
- Defined: PCSrc = out_valid AND Branch AND Zero, all from main. PCBranch is the registered BranchTarget.
- Undefined: PCSrc and PCBranch are tied 0. The BranchTarget, Zero and Branch storage flops are omitted. Branch is resolved elsewhere.

Structure
REQ-020 Shared package ex_mem_pkg SHALL hold:
- the DATA_W and REG_W defaults
- the control bit index constants (CTRL_REGWRITE=4 ... CTRL_BRANCH=0)
- the ex_mem_entry_t struct {alu_result, zero, wdata, wreg, ctrl, target}
REQ-021 Sub-module ex_mem_entry_reg (one entry plus its valid bit, load/clear) SHALL be instantiated twice, once for main and once for skid.

Verification
REQ-022 Scenario: Rst=1 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, MemCtrl=0, PCSrc=0.
REQ-023 Scenario: out_ready=1, entries ALUResult=0x10, 0x20, 0x30 on consecutive cycles -> MemAddr 0x10, 0x20, 0x30 on the following cycles, out_valid continuously 1.
REQ-024 Scenario: out_ready=0, entries A=0x100 then B=0x200 -> main=0x100, skid=0x200, in_ready=0. Then out_ready=1 -> 0x100 retires, then 0x200; in_ready=1 after skid drains.
REQ-025 Scenario: main and skid full, Flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed entry never appears.
REQ-026 Scenario (EX_MEM_BRANCH_RESOLVE_EN defined): Branch=1, Zero=1, BranchTarget=0x40 -> PCSrc=1, PCBranch=0x40 for that entry. With Zero=0 -> PCSrc=0. With macro undefined -> PCSrc=0 always.
REQ-027 Scenario: held entry Ctrl=5'b10000 (RegWrite); Rst=1 asserted mid-stall -> MemCtrl=0 next cycle and that entry never retires.
